// File: rtl/clock_div_gen.sv
// Multi-channel programmable clock divider with per-channel enable, rising-edge
// strobe and a global phase-sync restart. Each channel outputs a 50% duty clock of period 2*(div+1).
module clock_div_gen #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned DIVW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       en,
  input  logic [NCH*DIVW-1:0]  div,
  input  logic                 sync,
  output logic [NCH-1:0]       clk_out,
  output logic [NCH-1:0]       rise,
  output logic [NCH-1:0]       active
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t          state_q [NCH];
  state_t          state_d [NCH];
  logic [DIVW-1:0] cnt_q   [NCH];
  logic [DIVW-1:0] cnt_d   [NCH];
  logic [DIVW-1:0] r_q     [NCH];
  logic [DIVW-1:0] r_d     [NCH];
  logic [NCH-1:0]  clk_d;
  logic [NCH-1:0]  rise_d;
  logic [NCH-1:0]  active_d;

  // Per-channel next-state; sync overrides the normal phase sequencing.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      r_d[i]     = r_q[i];
      clk_d[i]   = clk_out[i];
      rise_d[i]  = 1'b0;

      if (sync) begin
        cnt_d[i] = '0;
        if (en[i]) begin
          state_d[i] = HIGH;
          clk_d[i]   = 1'b1;
          rise_d[i]  = 1'b1;
          r_d[i]     = div[i*DIVW +: DIVW];
        end else begin
          state_d[i] = IDLE;
          clk_d[i]   = 1'b0;
        end
      end else begin
        case (state_q[i])
          IDLE: begin
            if (en[i]) begin
              state_d[i] = HIGH;
              clk_d[i]   = 1'b1;
              rise_d[i]  = 1'b1;
              r_d[i]     = div[i*DIVW +: DIVW];
              cnt_d[i]   = '0;
            end
          end
          HIGH: begin
            // High phase always runs to completion regardless of en.
            if (cnt_q[i] != r_q[i]) begin
              cnt_d[i] = cnt_q[i] + DIVW'(1);
            end else begin
              state_d[i] = LOW;
              clk_d[i]   = 1'b0;
              cnt_d[i]   = '0;
            end
          end
          LOW: begin
            if (cnt_q[i] != r_q[i]) begin
              cnt_d[i] = cnt_q[i] + DIVW'(1);
            end else if (en[i]) begin
              state_d[i] = HIGH;
              clk_d[i]   = 1'b1;
              rise_d[i]  = 1'b1;
              r_d[i]     = div[i*DIVW +: DIVW];
              cnt_d[i]   = '0;
            end else begin
              state_d[i] = IDLE;
            end
          end
          default: begin
            state_d[i] = IDLE;
            clk_d[i]   = 1'b0;
            cnt_d[i]   = '0;
          end
        endcase
      end

      active_d[i] = (state_d[i] != IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        r_q[i]     <= '0;
      end
      clk_out <= '0;
      rise    <= '0;
      active  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        r_q[i]     <= r_d[i];
      end
      clk_out <= clk_d;
      rise    <= rise_d;
      active  <= active_d;
    end
  end

endmodule

// File: tb/tb_clock_div_gen.sv
// Testbench for clock_div_gen: a period-position reference model pushes expected
// {clk_out, rise, active} each edge; a negedge checker pops and compares.
module tb_clock_div_gen;

  localparam int unsigned NCH  = 4;
  localparam int unsigned DIVW = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NCH-1:0]      en;
  logic [NCH*DIVW-1:0] div;
  logic                sync;
  logic [NCH-1:0]      clk_out;
  logic [NCH-1:0]      rise;
  logic [NCH-1:0]      active;

  int n_checks = 0;
  int n_fail   = 0;

  int         mr  [NCH];
  int         pos [NCH];
  bit         run [NCH];
  logic [3*NCH-1:0] exp_q [$];

  clock_div_gen #(.NCH(NCH), .DIVW(DIVW)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div     (div),
    .sync    (sync),
    .clk_out (clk_out),
    .rise    (rise),
    .active  (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference model: track position within the current period instead of phases.
  always @(posedge clk or posedge rst) begin
    logic [NCH-1:0] e_clk, e_rise, e_act;
    int d;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        run[i] = 1'b0;
        pos[i] = 0;
        mr[i]  = 0;
      end
      exp_q.delete();
    end else begin
      for (int i = 0; i < NCH; i++) begin
        e_rise[i] = 1'b0;
        d = int'(div[i*DIVW +: DIVW]);
        if (sync) begin
          if (en[i]) begin
            run[i] = 1'b1; pos[i] = 0; mr[i] = d; e_rise[i] = 1'b1;
          end else begin
            run[i] = 1'b0; pos[i] = 0;
          end
        end else if (!run[i]) begin
          if (en[i]) begin
            run[i] = 1'b1; pos[i] = 0; mr[i] = d; e_rise[i] = 1'b1;
          end
        end else begin
          pos[i]++;
          if (pos[i] == 2 * (mr[i] + 1)) begin
            if (en[i]) begin
              pos[i] = 0; mr[i] = d; e_rise[i] = 1'b1;
            end else begin
              run[i] = 1'b0; pos[i] = 0;
            end
          end
        end
        e_clk[i] = run[i] && (pos[i] <= mr[i]);
        e_act[i] = run[i];
      end
      exp_q.push_back({e_clk, e_rise, e_act});
    end
  end

  always @(negedge clk) begin
    logic [3*NCH-1:0] e;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_clk_rise_active", 32'({clk_out, rise, active}), 32'(e));
    end
  end

  // Advances at least one cycle, then waits (bounded) for a rise on channel 0.
  task automatic wait_rise0(input string tag);
    int k = 0;
    @(negedge clk);
    while (!rise[0] && k < 600) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(rise[0]), 32'd1);
  endtask

  initial begin
    int k;
    en   = '0;
    div  = '0;
    sync = 1'b0;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_rise",    32'(rise),    32'd0);
    check("rst_active",  32'(active),  32'd0);
    rst = 1'b0;

    // Enable start on ch0 with div=2.
    en = 4'b0001;
    div[7:0] = 8'd2;
    @(negedge clk);
    check("start_latency", 32'(clk_out[0]), 32'd1);
    check("start_rise",    32'(rise[0]),    32'd1);
    repeat (20) @(negedge clk);
    check("idle_chans_active", 32'(active[3:1]), 32'd0);

    // Ratio change mid high phase.
    div[7:0] = 8'd1;
    wait_rise0("wait_rise_div1");
    wait_rise0("wait_rise_div1b");
    div[7:0] = 8'd4;
    repeat (16) @(negedge clk);

    // Graceful stop in cycle 1 of a div=3 high phase.
    div[7:0] = 8'd3;
    wait_rise0("wait_rise_div3");
    @(negedge clk);
    en[0] = 1'b0;
    repeat (12) @(negedge clk);
    check("stop_active0", 32'(active[0]), 32'd0);
    check("stop_clk0",    32'(clk_out[0]), 32'd0);

    // Sync alignment; ch2 is disabled while still finishing its period.
    en  = 4'b0111;
    div = {8'd0, 8'd5, 8'd3, 8'd1};
    repeat (7) @(negedge clk);
    check("pre_sync_active2", 32'(active[2]), 32'd1);
    en = 4'b0011;
    repeat (2) @(negedge clk);
    check("pre_sync_active2b", 32'(active[2]), 32'd1);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    check("sync_clk10",   32'(clk_out[1:0]), 32'd3);
    check("sync_rise10",  32'(rise[1:0]),    32'd3);
    check("sync_clk2",    32'(clk_out[2]),   32'd0);
    check("sync_active2", 32'(active[2]),    32'd0);
    repeat (10) @(negedge clk);

    // div=0 on ch3 alongside div=FF on ch0.
    en = 4'b1011;
    div[31:24] = 8'd0;
    div[7:0]   = 8'hFF;
    wait_rise0("wait_rise_ff");
    k = 0;
    while (clk_out[0] && k < 600) begin
      k++;
      @(negedge clk);
    end
    check("ff_high_len", 32'(k), 32'd256);
    k = 0;
    while (!clk_out[0] && k < 600) begin
      k++;
      @(negedge clk);
    end
    check("ff_low_len", 32'(k), 32'd256);

    // Async reset while ch0 is high, between clock edges.
    check("pre_rst_clk0", 32'(clk_out[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_clk_out", 32'(clk_out), 32'd0);
    check("async_rst_rise",    32'(rise),    32'd0);
    check("async_rst_active",  32'(active),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_clk0",  32'(clk_out[0]), 32'd1);
    check("post_rst_active", 32'(active),    32'(4'b1011));
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
